// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bus: two writeback requesters, clear control,
// the registered write channel and the conflict counter.
interface regfile_write_arbiter_if #(
    parameter int unsigned COUNT_W = 16
);
    logic               req0_valid;
    logic [4:0]         req0_addr;
    logic [31:0]        req0_data;
    logic               req0_ready;
    logic               req1_valid;
    logic [4:0]         req1_addr;
    logic [31:0]        req1_data;
    logic               req1_ready;
    logic               clear_start;
    logic               clear_busy;
    logic               clear_done;
    logic               wr_ena;
    logic [4:0]         wr_addr;
    logic [31:0]        wr_data;
    logic [COUNT_W-1:0] conflict_count;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clear_start,
        input  req0_ready, req1_ready, clear_busy, clear_done,
        input  wr_ena, wr_addr, wr_data, conflict_count
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clear_start,
        output req0_ready, req1_ready, clear_busy, clear_done,
        output wr_ena, wr_addr, wr_data, conflict_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter between ALU and load writeback onto one register-file
// write port, with a sweep that clears x1..x31.
module regfile_write_arbiter #(
    parameter logic [31:0] CLEAR_VALUE = 32'd0,
    parameter int unsigned COUNT_W     = 16
) (
    input logic                     clk,
    input logic                     rst,
    regfile_write_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {StArb, StClear} state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;  // 1: req1 wins the next conflict
    logic               wr_ena_q, wr_ena_d;
    logic [4:0]         wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               clear_done_q, clear_done_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               gnt0, gnt1;
    logic [4:0]         sel_addr;
    logic [31:0]        sel_data;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        wr_ena_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        clear_done_d = 1'b0;
        cnt_d        = cnt_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        sel_addr     = 5'd0;
        sel_data     = 32'd0;
        unique case (state_q)
            StArb: begin
                if (bus.clear_start) begin
                    state_d   = StClear;
                    wr_ena_d  = 1'b1;
                    wr_addr_d = 5'd1;
                    wr_data_d = CLEAR_VALUE;
                end else begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                        if (cnt_q != '1) cnt_d = cnt_q + COUNT_W'(1);
                    end else begin
                        gnt0 = bus.req0_valid;
                        gnt1 = bus.req1_valid;
                    end
                    sel_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
                    sel_data = gnt1 ? bus.req1_data : bus.req0_data;
                    if (gnt0 || gnt1) begin
                        ptr_d = gnt0;
                        // x0 is hardwired: accept the request but drop the write
                        if (sel_addr != 5'd0) begin
                            wr_ena_d  = 1'b1;
                            wr_addr_d = sel_addr;
                            wr_data_d = sel_data;
                        end
                    end
                end
            end
            StClear: begin
                if (wr_addr_q == 5'd31) begin
                    state_d = StArb;
                end else begin
                    wr_ena_d     = 1'b1;
                    wr_addr_d    = wr_addr_q + 5'd1;
                    wr_data_d    = CLEAR_VALUE;
                    clear_done_d = (wr_addr_q == 5'd30);
                end
            end
            default: state_d = StArb;
        endcase
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StArb;
            ptr_q        <= 1'b0;
            wr_ena_q     <= 1'b0;
            wr_addr_q    <= 5'd0;
            wr_data_q    <= 32'd0;
            clear_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            wr_ena_q     <= wr_ena_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            clear_done_q <= clear_done_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req0_ready     = gnt0;
    assign bus.req1_ready     = gnt1;
    assign bus.clear_busy     = (state_q == StClear);
    assign bus.clear_done     = clear_done_q;
    assign bus.wr_ena         = wr_ena_q;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.wr_data        = wr_data_q;
    assign bus.conflict_count = cnt_q;
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_VALUE, default 32'd0, the data written to x01..x31 during a clear sweep.
REQ-002 SHALL have parameter COUNT_W, default 16, the width of the conflict counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each, write request from requester 0 (ALU writeback) and requester 1 (load writeback).
REQ-006 SHALL have ports req0_addr / req1_addr, input, 5 each, destination register.
REQ-007 SHALL have ports req0_data / req1_data, input, 32 each, write data.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1 each, combinational accept indication.
REQ-009 SHALL have port clear_start, input, 1, pulse that requests a clear sweep.
REQ-010 SHALL have ports clear_busy and clear_done, output, 1 each, sweep in progress and single-cycle sweep-complete pulse.
REQ-011 SHALL have ports wr_ena (1), wr_addr (5) and wr_data (32), registered outputs that drive the register-file write channel.
REQ-012 SHALL have port conflict_count, output, COUNT_W, the count of arbitration conflicts.

Function
REQ-013 SHALL implement FSM states ARB and CLEAR; reset enters ARB.
REQ-014 SHALL treat a request as transferred when valid&ready are both high at a clock edge; a requester holds valid/addr/data stable until that edge.
REQ-015 SHALL, in ARB with clear_start=0, grant the only valid requester; when both are valid, it grants the requester not granted most recently (round-robin pointer).
REQ-016 SHALL update the round-robin pointer only on a transfer.
REQ-017 SHALL assert ready to at most one requester per cycle; readyX=0 whenever reqX_valid=0.
REQ-018 SHALL present a transfer at edge N on wr_ena=1, wr_addr and wr_data during cycle N+1 (latency 1); with no transfer, wr_ena=0 next cycle and wr_addr/wr_data hold their previous values.
REQ-019 SHALL accept a transfer with addr=0 (ready asserted) but keep wr_ena=0 for it (x0 write dropped).
REQ-020 SHALL increment conflict_count for each ARB cycle in which both valids are high and clear_start=0; the counter saturates at all-ones and does not wrap.
REQ-021 SHALL, with clear_start=1 in ARB, go to CLEAR; both readys stay 0 in that cycle (clear beats requests).
REQ-022 SHALL, for clear_start sampled at edge N, drive wr_ena=1, wr_addr=k and wr_data=CLEAR_VALUE during cycle N+k for k=1..31, with clear_busy=1 over cycles N+1..N+31.
REQ-023 SHALL hold both readys at 0 throughout CLEAR; clear_start is ignored in CLEAR.
REQ-024 SHALL pulse clear_done=1 only in cycle N+31 (same cycle as the x31 write), then return to ARB; arbitration resumes in cycle N+32.
REQ-025 SHALL not overlap writes: a transfer accepted at edge N-1 appears in cycle N, and sweep writes begin in N+1.

Reset
REQ-026 SHALL, when rst=1 at an edge, set state=ARB, wr_ena=0, wr_addr=0, wr_data=0, clear_busy=0, clear_done=0, conflict_count=0 and the pointer to favour req0; rst has priority over all inputs.
REQ-027 SHALL, on reset during CLEAR, abort the sweep: no further sweep writes and no clear_done.
REQ-028 SHALL hold readys at 0 in any cycle where rst=1.

Verification
REQ-029 SHALL cover a single request: req1 valid, addr=5, data=0xDEADBEEF at edge N -> cycle N+1 wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF; req0_ready=0 throughout.
REQ-030 SHALL cover contention: both valid for 4 consecutive cycles after reset -> grants req0, req1, req0, req1; conflict_count=4.
REQ-031 SHALL cover an x0 drop: req0 valid, addr=0, data=0x1234 -> req0_ready=1, wr_ena=0 next cycle.
REQ-032 SHALL cover a clear sweep: clear_start pulsed with both valids high -> readys 0 for 32 cycles, wr_addr 1..31 with wr_data=0, clear_done only with wr_addr=31, req0 granted in cycle N+32.
REQ-033 SHALL cover reset mid-sweep: rst at sweep cycle 10 -> wr_ena=0 after reset, clear_busy=0, no clear_done, conflict_count=0.
REQ-034 SHALL cover counter saturation: with COUNT_W=4, 20 conflict cycles -> conflict_count=15.
